// File: rtl/gb_arb_pkg.sv
// Shared types and default widths for the global-buffer arbiter.
package gb_arb_pkg;

  localparam int GB_NUM_REQ   = 4;
  localparam int GB_ADDR_W    = 10;
  localparam int GB_DATA_W    = 128;
  localparam int GB_MAX_BURST = 16;
  localparam int GB_RD_LAT    = 1;
  localparam int GB_OWN_W     = $clog2(GB_NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Read-return tag; the owner field is sized for GB_NUM_REQ requesters.
  typedef struct packed {
    logic                v;
    logic [GB_OWN_W-1:0] owner;
  } tag_t;

endpackage

// File: rtl/gb_arbiter_rr_pick.sv
// Cyclic priority encoder: first set request at or after the pointer wins.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_j;

  // Walk the requesters starting at the pointer, wrapping past N-1 to 0.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[IDX_W'(w_j)]) begin
        o_any                = 1'b1;
        o_gnt[IDX_W'(w_j)]   = 1'b1;
        o_idx                = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/gb_arbiter.sv
// Round-robin burst arbiter in front of the single global_buffer port.
module gb_arbiter
  import gb_arb_pkg::*;
#(
  parameter int NUM_REQ   = GB_NUM_REQ,
  parameter int ADDR_W    = GB_ADDR_W,
  parameter int DATA_W    = GB_DATA_W,
  parameter int MAX_BURST = GB_MAX_BURST,
  parameter int RD_LAT    = GB_RD_LAT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_valid_i,
  input  logic [NUM_REQ-1:0]                          req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]              req_addr_i,
  input  logic [NUM_REQ-1:0][$clog2(MAX_BURST)-1:0]   req_len_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]              req_wdata_i,
  output logic [NUM_REQ-1:0]                          req_ready_o,
  output logic [NUM_REQ-1:0]                          rsp_valid_o,
  output logic [DATA_W-1:0]                           rsp_rdata_o,
  output logic [ADDR_W-1:0]                           gb_addr_o,
  output logic [DATA_W-1:0]                           gb_wr_data_o,
  output logic                                        gb_wr_en_o,
  input  logic [DATA_W-1:0]                           gb_rd_data_i,
  input  logic                                        gb_valid_i,
  output logic                                        busy_o,
  output logic [$clog2(NUM_REQ)-1:0]                  owner_o
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int LEN_W = $clog2(MAX_BURST);

  state_t             r_state, w_state_nxt;
  logic [OWN_W-1:0]   r_ptr, r_owner;
  logic               r_we;
  logic [ADDR_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_len, r_beat;
  logic [ADDR_W-1:0]  r_gb_addr;
  logic [DATA_W-1:0]  r_gb_wdata;
  logic               r_gb_we;
  tag_t [RD_LAT:0]    r_tag;

  logic [NUM_REQ-1:0] w_gnt;
  logic [OWN_W-1:0]   w_idx;
  logic               w_any;
  logic               w_acc, w_last;
  tag_t               w_tag_out;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_acc  = (r_state == BURST) && req_valid_i[r_owner];
  assign w_last = w_acc && (r_beat == r_len);

  // Next state and the owner's combinational ready; no ready in the grant cycle.
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = '0;
    case (r_state)
      IDLE:  if (w_any) w_state_nxt = BURST;
      BURST: begin
        req_ready_o[r_owner] = req_valid_i[r_owner];
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, grant latch, beat counter and registered buffer drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_gb_addr  <= '0;
      r_gb_wdata <= '0;
      r_gb_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gb_we <= 1'b0;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_idx;
        r_we    <= |(w_gnt & req_we_i);
        r_base  <= req_addr_i[w_idx];
        r_len   <= req_len_i[w_idx];
        r_beat  <= '0;
      end
      if (w_acc) begin
        // Address wraps naturally at the top of the buffer.
        r_gb_addr <= r_base + ADDR_W'(r_beat);
        r_gb_we   <= r_we;
        if (r_we) r_gb_wdata <= req_wdata_i[r_owner];
        r_beat    <= r_beat + 1'b1;
        if (w_last) r_ptr <= (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
    end
  end

  // Read tags ride alongside gb_addr_o and come out when buffer data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= '{v: w_acc && !r_we, owner: r_owner};
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_out = r_tag[RD_LAT];

  // Steer returning read data to the requester that issued it.
  always_comb begin
    rsp_valid_o = '0;
    if (w_tag_out.v) rsp_valid_o[w_tag_out.owner] = 1'b1;
  end

  assign rsp_rdata_o  = w_tag_out.v ? gb_rd_data_i : '0;
  assign gb_addr_o    = r_gb_addr;
  assign gb_wr_data_o = r_gb_wdata;
  assign gb_wr_en_o   = r_gb_we;
  assign busy_o       = (r_state == BURST);
  assign owner_o      = r_owner;

  // Buffer read-valid must line up with the tag leaving the pipe.
  a_rd_align: assert property (@(posedge clk) disable iff (rst) gb_valid_i == w_tag_out.v);

endmodule

// File: tb/tb_gb_arbiter.sv
// Scoreboard bench for gb_arbiter with a behavioural global_buffer model.
module tb_gb_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 128;
  localparam int MAX_BURST = 16;
  localparam int RD_LAT    = 1;
  localparam int LEN_W     = $clog2(MAX_BURST);
  localparam int OWN_W     = $clog2(NUM_REQ);
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REQ-1:0]              req_valid_i, req_we_i, req_ready_o, rsp_valid_o;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_i;
  logic [NUM_REQ-1:0][LEN_W-1:0]   req_len_i;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata_i;
  logic [DATA_W-1:0]               rsp_rdata_o, gb_wr_data_o, gb_rd_data_i;
  logic [ADDR_W-1:0]               gb_addr_o;
  logic                            gb_wr_en_o, gb_valid_i, busy_o;
  logic [OWN_W-1:0]                owner_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gb_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .gb_addr_o(gb_addr_o), .gb_wr_data_o(gb_wr_data_o), .gb_wr_en_o(gb_wr_en_o),
    .gb_rd_data_i(gb_rd_data_i), .gb_valid_i(gb_valid_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  function automatic logic [DATA_W-1:0] pat(int a);
    logic [9:0] aa;
    aa = a[9:0];
    return {4{16'hBEEF, 6'd0, aa}};
  endfunction

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Buffer model: preset on reset, RD_LAT read latency, valid tracks read beats.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              r_issue;
  logic [RD_LAT-1:0] r_vp;
  logic [DATA_W-1:0] r_dp [RD_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue <= 1'b0;
      r_vp    <= '0;
      for (int a = 0; a < DEPTH; a++) mem[a] <= pat(a);
    end else begin
      r_issue  <= |(req_ready_o & req_valid_i & ~req_we_i);
      r_vp[0]  <= r_issue;
      r_dp[0]  <= mem[gb_addr_o];
      for (int i = 1; i < RD_LAT; i++) begin
        r_vp[i] <= r_vp[i-1];
        r_dp[i] <= r_dp[i-1];
      end
      if (gb_wr_en_o) mem[gb_addr_o] <= gb_wr_data_o;
    end
  end
  assign gb_valid_i   = r_vp[RD_LAT-1];
  assign gb_rd_data_i = r_dp[RD_LAT-1];

  typedef struct {
    logic [DATA_W-1:0] data;
    int                addr;
    int                who;
    int                cyc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  int   own_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  bit   d_act [NUM_REQ];
  bit   d_we  [NUM_REQ];
  int   d_base[NUM_REQ], d_len[NUM_REQ], d_beat[NUM_REQ];
  int   d_stall_at[NUM_REQ], d_stall_n[NUM_REQ], d_left[NUM_REQ];
  logic [DATA_W-1:0] d_wdata[NUM_REQ];

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt, wr_first, busy_fall, c0;
  bit prev_busy = 1'b0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (wr_q.size() != 0) || (rd_q.size() != 0) || (own_q.size() != 0);
    for (int k = 0; k < NUM_REQ; k++) p = p | d_act[k];
    return p;
  endfunction

  task automatic start(int k, bit we, int base, int len, int stall_at = -1, int stall_n = 0);
    d_act[k] = 1'b1; d_we[k] = we; d_base[k] = base; d_len[k] = len; d_beat[k] = 0;
    d_stall_at[k] = stall_at; d_stall_n[k] = stall_n; d_left[k] = 0;
    d_wdata[k] = rnd128();
    req_we_i[k] = we; req_addr_i[k] = ADDR_W'(base); req_len_i[k] = LEN_W'(len);
    req_wdata_i[k] = d_wdata[k]; req_valid_i[k] = 1'b1;
    own_q.push_back(k);
  endtask

  // One cycle: compare outputs at negedge, then advance requesters after posedge.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    exp_t e;
    @(negedge clk);
    chk("rdy_legal", {$onehot0(req_ready_o), (req_ready_o & ~req_valid_i) == '0}, 2'b11);
    if (gb_wr_en_o) begin
      wr_cnt++;
      if (wr_first < 0) wr_first = cyc;
      if (wr_q.size() == 0) chk("wr_unexp", gb_addr_o, 128'hX);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", gb_addr_o, e.addr);
        chk("wr_data", gb_wr_data_o, e.data);
        chk("wr_cyc", cyc, e.cyc);
      end
    end
    if (rsp_valid_o != '0) begin
      if (rd_q.size() == 0) chk("rsp_unexp", rsp_valid_o, 0);
      else begin
        e = rd_q.pop_front();
        chk("rsp_who", rsp_valid_o, 1 << e.who);
        chk("rsp_data", rsp_rdata_o, e.data);
        chk("rsp_cyc", cyc, e.cyc);
      end
    end
    if (busy_o && !prev_busy) begin
      if (own_q.size() == 0) chk("grant_unexp", owner_o, 128'hX);
      else chk("owner", owner_o, own_q.pop_front());
    end
    if (!busy_o && prev_busy) busy_fall = cyc;
    prev_busy = busy_o;
    acc = req_ready_o & req_valid_i;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc[k]) begin
        e.addr = (d_base[k] + d_beat[k]) % DEPTH;
        e.who  = k;
        if (d_we[k]) begin
          e.data = d_wdata[k]; e.cyc = cyc;
          wr_q.push_back(e);
          ref_mem[e.addr] = e.data;
        end else begin
          e.data = ref_mem[e.addr]; e.cyc = cyc + RD_LAT;
          rd_q.push_back(e);
        end
        // Mid-burst changes to addr/len must be ignored by the arbiter.
        req_addr_i[k] = ADDR_W'($urandom);
        req_len_i[k]  = LEN_W'($urandom);
        if (d_beat[k] == d_len[k]) begin
          d_act[k] = 1'b0; req_valid_i[k] = 1'b0;
        end else begin
          if (d_beat[k] == d_stall_at[k] && d_stall_n[k] > 0) begin
            d_left[k] = d_stall_n[k]; req_valid_i[k] = 1'b0;
          end
          d_beat[k]++;
          d_wdata[k] = rnd128(); req_wdata_i[k] = d_wdata[k];
        end
      end else if (d_act[k] && d_left[k] > 0) begin
        d_left[k]--;
        if (d_left[k] == 0) req_valid_i[k] = 1'b1;
      end
    end
  endtask

  task automatic wait_done(int maxc);
    int n;
    n = 0;
    while (n < maxc && pending()) begin tick(); n++; end
    if (pending()) chk("timeout", 1, 0);
    tick(); tick();
  endtask

  initial begin
    req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_len_i = '0; req_wdata_i = '0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = pat(a);
    for (int k = 0; k < NUM_REQ; k++) d_act[k] = 1'b0;
    wr_cnt = 0; wr_first = -1; busy_fall = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_wren", gb_wr_en_o, 0);
    chk("rst_addr", gb_addr_o, 0);
    chk("rst_rsp", rsp_valid_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write burst: 4 beats from addr 5, first write two cycles after valid.
    wr_cnt = 0; wr_first = -1; c0 = cyc;
    start(0, 1'b1, 5, 3);
    wait_done(100);
    chk("t1_first", wr_first, c0 + 2);
    chk("t1_cnt", wr_cnt, 4);
    chk("t1_busyfall", busy_fall, c0 + 5);

    // Read back addr 5 via requester 3; also returns the pointer to 0.
    start(3, 1'b0, 5, 0);
    wait_done(100);

    // All four single-beat reads at once: grants 0,1,2,3.
    for (int k = 0; k < NUM_REQ; k++) start(k, 1'b0, 16 + k, 0);
    wait_done(200);

    // Read burst across the top of the address space.
    start(2, 1'b0, 1022, 3);
    wait_done(100);

    // Write burst with a 3-cycle requester stall; req3 waits for its turn.
    wr_cnt = 0;
    start(1, 1'b1, 40, 7, 2, 3);
    tick(); tick();
    start(3, 1'b0, 40, 0);
    wait_done(200);
    chk("t4_cnt", wr_cnt, 8);

    // Move the pointer to 2, then reset during a read burst with a read in flight.
    start(1, 1'b1, 100, 0);
    wait_done(100);
    start(2, 1'b0, 200, 3);
    for (int i = 0; i < 20 && d_beat[2] == 0; i++) tick();
    rst = 1'b1;
    req_valid_i = '0;
    for (int k = 0; k < NUM_REQ; k++) d_act[k] = 1'b0;
    wr_q.delete(); rd_q.delete(); own_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy", busy_o, 0);
    chk("t5_owner", owner_o, 0);
    chk("t5_wren", gb_wr_en_o, 0);
    chk("t5_addr", gb_addr_o, 0);
    chk("t5_rsp", rsp_valid_o, 0);
    chk("t5_rdata", rsp_rdata_o, 0);
    rst = 1'b0;
    prev_busy = 1'b0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = pat(a);
    @(posedge clk); #1;
    // Pointer back at 0: requester 1 wins over 3.
    start(1, 1'b0, 300, 0);
    start(3, 1'b0, 301, 0);
    wait_done(100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gb_arbiter.md
Name: gb_arbiter

Overview:
Round-robin burst arbiter that shares the single global_buffer port among NUM_REQ requesters (filter loader, ifmap loader, psum writeback, host DMA). It grants one requester at a time for a burst of up to MAX_BURST consecutive-address beats and drives the buffer's addr/wr_data/wr_en. Read data returned by the buffer is steered back to the requester that issued the read.

Parameters:
NUM_REQ, 4, number of requesters
ADDR_W, 10, global buffer word-address width (depth 1024)
DATA_W, 128, buffer interface width (16 x 8-bit)
MAX_BURST, 16, maximum beats per grant
RD_LAT, 1, cycles from address on gb_addr_o to gb_valid_i/gb_rd_data_i

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid_i  in  NUM_REQ  per-requester beat valid
req_we_i  in  NUM_REQ  1 = write burst, 0 = read burst; sampled at grant
req_addr_i  in  NUM_REQ x ADDR_W  burst base address; sampled at grant
req_len_i  in  NUM_REQ x $clog2(MAX_BURST)  beats minus 1; sampled at grant
req_wdata_i  in  NUM_REQ x DATA_W  write data for the current beat
req_ready_o  out  NUM_REQ  beat accepted this cycle
rsp_valid_o  out  NUM_REQ  read data valid for requester k
rsp_rdata_o  out  DATA_W  shared read-data bus
gb_addr_o  out  ADDR_W  to global_buffer addr_i
gb_wr_data_o  out  DATA_W  to global_buffer wr_data_i
gb_wr_en_o  out  1  to global_buffer wr_en
gb_rd_data_i  in  DATA_W  from global_buffer rd_data_o
gb_valid_i  in  1  from global_buffer valid_o
busy_o  out  1  burst in progress
owner_o  out  $clog2(NUM_REQ)  current or last grant owner

Behaviour:
- Reset: state IDLE; rr pointer 0; all outputs 0; tag pipe cleared. In-flight reads are dropped and produce no rsp_valid_o.
- FSM IDLE:
  - If any req_valid_i is set, pick the first set bit at or after the rr pointer (cyclic). Latch owner, we, addr, len; beat counter = 0; go to BURST.
  - No ready is asserted in the grant cycle.
- FSM BURST:
  - req_ready_o[owner] = req_valid_i[owner] (combinational). All other ready bits are 0.
  - Accepted beat at cycle t: registered outputs at t+1 drive gb_addr_o = base + beat (mod 2^ADDR_W, wraps), gb_wr_en_o = we, gb_wr_data_o = req_wdata_i[owner] (writes only).
  - Cycles with no accepted beat: gb_wr_en_o = 0, gb_addr_o holds its value, grant is held (stall). There is no timeout.
  - When the beat with counter == len is accepted: go to IDLE; rr pointer = owner+1 mod NUM_REQ.
  - One idle bubble is always inserted between bursts.
- Read tracking:
  - Each accepted read beat pushes {valid, owner} into an RD_LAT+1 stage tag shift register aligned with gb_addr_o.
  - At the output stage: rsp_valid_o[tag.owner] = 1 and rsp_rdata_o = gb_rd_data_i. Worst-case latency is req accept -> rsp_valid_o = RD_LAT+1 cycles.
  - Assertion: gb_valid_i equals tag output valid.
- A requester dropping req_valid_i in IDLE before grant loses nothing; arbitration is re-evaluated every IDLE cycle.
- busy_o = (state == BURST). owner_o updates at grant.
- Requester changes to we/addr/len mid-burst are ignored.

Decomposition:
- Package gb_arb_pkg holds:
  - state_t enum {IDLE, BURST}
  - tag struct {logic v; logic [$clog2(NUM_REQ)-1:0] owner}
  - default width constants
- Sub-module rr_pick: combinational cyclic priority encoder (req vector, pointer -> one-hot grant, index). It is reused later by the PE-array NoC scheduler.

Test Plan:
- Reset, then req0 writes addr 5, len 3, data A..D -> gb_wr_en_o is high 4 cycles starting 2 cycles after req_valid_i, with addresses 5, 6, 7, 8 and data A..D; busy_o falls after the last beat.
- All four requesters assert len 0 reads at the same cycle, pointer 0 -> grant order 0, 1, 2, 3; owner_o follows that sequence; each rsp_valid_o[k] pulses once, RD_LAT+1 cycles after its ready.
- Req2 reads addr 1022, len 3 -> gb_addr_o goes 1022, 1023, 0, 1; the rsp_valid_o[2] pulses carry the matching buffer data.
- Req1 write burst len 7 drops req_valid_i for 3 cycles after beat 2 -> gb_wr_en_o is low for 3 cycles with no other grant; beats resume at addr base+3; 8 writes total.
- Rst asserted mid read burst with 1 read in flight -> next cycle all outputs 0 and state IDLE; no rsp_valid_o pulse for the dropped read; the next request is granted from pointer 0.
